// File: rtl/alu_result_checker.sv
// Purpose: self-check stage after the registered ALU; delays expected values and scores each ALU result.
// Latency: compare when the LATENCY-deep expected pipeline emerges; mismatch and counters update one cycle later.
// Backpressure: none; every in_valid accepted in RUN is compared. Optional capture outputs: ALU_CHK_CAPTURE_EN.
module alu_result_checker #(
    parameter int NUM_PATTERNS = 6,
    parameter int LATENCY      = 1,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_exp_result,
    input  logic [2:0]       in_exp_zcv,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] pat_count,
    output logic [CNT_W-1:0] err_count
`ifdef ALU_CHK_CAPTURE_EN
    ,
    output logic [CNT_W-1:0] fail_index,
    output logic [31:0]      fail_result,
    output logic [2:0]       fail_zcv,
    output logic             fail_valid
`endif
);

    localparam int ISS_W = $clog2(NUM_PATTERNS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ISS_W-1:0]   issued;
    logic [ISS_W-1:0]   issued_nxt;
    logic               start_ok;
    logic               accept;
    logic               cmp_vld;
    logic               cmp_fail;
    logic               upstream_busy;
    logic [2:0]         alu_zcv;

    // Stage 0 takes the newly issued pattern; stage LATENCY-1 lines up with the ALU output.
    logic [LATENCY-1:0] pipe_vld;
    logic [3:0]         pipe_op  [LATENCY];
    logic [31:0]        pipe_res [LATENCY];
    logic [2:0]         pipe_zcv [LATENCY];

    assign alu_zcv    = {alu_zero, alu_cout, alu_overflow};
    assign start_ok   = start && (state == IDLE || state == DONE);
    assign accept     = (state == RUN) && in_valid && (issued < ISS_W'(NUM_PATTERNS));
    assign issued_nxt = issued + ISS_W'(accept);
    assign cmp_vld    = pipe_vld[LATENCY-1];

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    // Result must match exactly; ADD/SUB check all flags, other ops only the zero flag.
    always_comb begin
        cmp_fail = 1'b0;
        if (pipe_res[LATENCY-1] != alu_result) cmp_fail = 1'b1;
        if (pipe_op[LATENCY-1] == 4'd2 || pipe_op[LATENCY-1] == 4'd6) begin
            if (pipe_zcv[LATENCY-1] != alu_zcv) cmp_fail = 1'b1;
        end else if (pipe_zcv[LATENCY-1][2] != alu_zero) begin
            cmp_fail = 1'b1;
        end
    end

    // Any valid short of the output stage means more compares are still coming.
    always_comb begin
        upstream_busy = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) upstream_busy = upstream_busy | pipe_vld[i];
    end

    // Next-state: leave RUN on the edge that accepts the last pattern so done lands LATENCY+1 after it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (issued_nxt == ISS_W'(NUM_PATTERNS)) state_nxt = DRAIN;
            DRAIN:   if (!upstream_busy) state_nxt = DONE;
            DONE:    if (start_ok) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Issue count, per-run statistics and the registered mismatch pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued    <= '0;
            pat_count <= '0;
            err_count <= '0;
            mismatch  <= 1'b0;
        end else begin
            mismatch <= cmp_vld && cmp_fail;
            if (start_ok) begin
                issued    <= '0;
                pat_count <= '0;
                err_count <= '0;
            end else begin
                issued <= issued_nxt;
                if (cmp_vld) begin
                    pat_count <= pat_count + CNT_W'(1);
                    if (cmp_fail && err_count != '1) err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

    // Pipeline valids are reset so in-flight entries vanish on rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    // Expected-value payload shifts freely; it is only looked at alongside its valid.
    always_ff @(posedge clk) begin
        pipe_op[0]  <= in_op;
        pipe_res[0] <= in_exp_result;
        pipe_zcv[0] <= in_exp_zcv;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_op[i]  <= pipe_op[i-1];
            pipe_res[i] <= pipe_res[i-1];
            pipe_zcv[i] <= pipe_zcv[i-1];
        end
    end

`ifdef ALU_CHK_CAPTURE_EN
    // Snapshot the first failure of the run; later failures leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            fail_valid  <= 1'b0;
            fail_index  <= '0;
            fail_result <= '0;
            fail_zcv    <= '0;
        end else if (cmp_vld && cmp_fail && !fail_valid) begin
            fail_valid  <= 1'b1;
            fail_index  <= pat_count;
            fail_result <= alu_result;
            fail_zcv    <= alu_zcv;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: two instances (LATENCY=1/CNT_W=6 and LATENCY=2/CNT_W=2) share stimulus;
// ALU outputs come from per-instance delay lines fed with the vector's "actual" values.
// Define ALU_CHK_CAPTURE_EN to exercise the first-failure capture outputs.
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_exp_result;
    logic [2:0]  in_exp_zcv;
    logic [31:0] act_res, s1_res, s2_res;
    logic [2:0]  act_zcv, s1_zcv, s2_zcv;

    logic        busy1, done1, pass1, mism1;
    logic [5:0]  pat1, err1;
    logic        busy2, done2, pass2, mism2;
    logic [1:0]  pat2, err2;
`ifdef ALU_CHK_CAPTURE_EN
    logic [5:0]  fi1;
    logic [1:0]  fi2;
    logic [31:0] fr1, fr2;
    logic [2:0]  fz1, fz2;
    logic        fv1, fv2;
`endif

    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   q1[$];
    bit   q2[$];
    logic [5:0] prev1 = '0;
    logic [1:0] prev2 = '0;
    bit   e1, e2;

    always #5 clk = ~clk;

    // Stand-in for the registered ALU: actual values appear 1 or 2 cycles after issue.
    always @(posedge clk) begin
        s1_res <= act_res;
        s1_zcv <= act_zcv;
        s2_res <= s1_res;
        s2_zcv <= s1_zcv;
    end

    alu_result_checker #(.NUM_PATTERNS(6), .LATENCY(1), .CNT_W(6)) u_l1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_op(in_op),
        .in_exp_result(in_exp_result), .in_exp_zcv(in_exp_zcv),
        .alu_result(s1_res), .alu_zero(s1_zcv[2]), .alu_cout(s1_zcv[1]), .alu_overflow(s1_zcv[0]),
        .busy(busy1), .done(done1), .pass(pass1), .mismatch(mism1),
        .pat_count(pat1), .err_count(err1)
`ifdef ALU_CHK_CAPTURE_EN
        , .fail_index(fi1), .fail_result(fr1), .fail_zcv(fz1), .fail_valid(fv1)
`endif
    );

    alu_result_checker #(.NUM_PATTERNS(6), .LATENCY(2), .CNT_W(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_op(in_op),
        .in_exp_result(in_exp_result), .in_exp_zcv(in_exp_zcv),
        .alu_result(s2_res), .alu_zero(s2_zcv[2]), .alu_cout(s2_zcv[1]), .alu_overflow(s2_zcv[0]),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch(mism2),
        .pat_count(pat2), .err_count(err2)
`ifdef ALU_CHK_CAPTURE_EN
        , .fail_index(fi2), .fail_result(fr2), .fail_zcv(fz2), .fail_valid(fv2)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor for the LATENCY=1 instance: every pat_count step is one compare.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pat1 === prev1 + 6'd1) begin
                    chk("l1_compare_expected", {31'd0, q1.size() > 0}, 32'd1);
                    if (q1.size() > 0) begin
                        e1 = q1.pop_front();
                        chk("l1_mismatch_pulse", {31'd0, mism1}, {31'd0, e1});
                    end
                end else begin
                    chk("l1_idle_mismatch", {31'd0, mism1}, 32'd0);
                end
                prev1 = pat1;
                if (rst_n === 1'b0) begin
                    q1.delete();
                    prev1 = '0;
                end
            end
        end
    end

    // Monitor for the LATENCY=2 instance (2-bit counters wrap on pat_count).
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pat2 === prev2 + 2'd1) begin
                    chk("l2_compare_expected", {31'd0, q2.size() > 0}, 32'd1);
                    if (q2.size() > 0) begin
                        e2 = q2.pop_front();
                        chk("l2_mismatch_pulse", {31'd0, mism2}, {31'd0, e2});
                    end
                end else begin
                    chk("l2_idle_mismatch", {31'd0, mism2}, 32'd0);
                end
                prev2 = pat2;
                if (rst_n === 1'b0) begin
                    q2.delete();
                    prev2 = '0;
                end
            end
        end
    end

    // One issue cycle: expected values to the checker, actual values into the ALU stand-in.
    task automatic drive(input bit vld, input bit push, input bit exp_fail,
                         input logic [3:0] op, input logic [31:0] er, input logic [2:0] ez,
                         input logic [31:0] ar, input logic [2:0] az);
        in_valid = vld; in_op = op; in_exp_result = er; in_exp_zcv = ez;
        act_res = ar; act_zcv = az;
        if (push) begin
            q1.push_back(exp_fail);
            q2.push_back(exp_fail);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; act_res = 32'hDEADBEEF; act_zcv = 3'b101;
    endtask

    // Correct patterns: ALU returns exactly the expected values.
    task automatic good(input int i);
        case (i)
            0: drive(1, 1, 0, 4'd0,  32'h000F000F, 3'b000, 32'h000F000F, 3'b000);
            1: drive(1, 1, 0, 4'd1,  32'hFFFFFFFF, 3'b000, 32'hFFFFFFFF, 3'b000);
            2: drive(1, 1, 0, 4'd2,  32'h00000008, 3'b000, 32'h00000008, 3'b000);
            3: drive(1, 1, 0, 4'd6,  32'h00000000, 3'b110, 32'h00000000, 3'b110);
            4: drive(1, 1, 0, 4'd7,  32'h00000001, 3'b000, 32'h00000001, 3'b000);
            default: drive(1, 1, 0, 4'd12, 32'hFFFFFFFF, 3'b000, 32'hFFFFFFFF, 3'b000);
        endcase
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(done1 === 1'b1 && done2 === 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_reached"}, {31'd0, done1 === 1'b1 && done2 === 1'b1}, 32'd1);
    endtask

    task automatic run_end(input string tag, input int p1, input int ee1,
                           input int p2, input int ee2, input int ps);
        chk({tag, "_pat1"},  pat1,  p1);
        chk({tag, "_err1"},  err1,  ee1);
        chk({tag, "_pat2"},  pat2,  p2);
        chk({tag, "_err2"},  err2,  ee2);
        chk({tag, "_pass1"}, pass1, ps);
        chk({tag, "_pass2"}, pass2, ps);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_q1_drained"}, q1.size(), 0);
        chk({tag, "_q2_drained"}, q2.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy1"}, busy1, 0); chk({tag, "_done1"}, done1, 0);
        chk({tag, "_pass1"}, pass1, 0); chk({tag, "_mism1"}, mism1, 0);
        chk({tag, "_pat1"},  pat1,  0); chk({tag, "_err1"},  err1,  0);
        chk({tag, "_busy2"}, busy2, 0); chk({tag, "_done2"}, done2, 0);
        chk({tag, "_pat2"},  pat2,  0); chk({tag, "_err2"},  err2,  0);
`ifdef ALU_CHK_CAPTURE_EN
        chk({tag, "_fv1"}, fv1, 0); chk({tag, "_fi1"}, fi1, 0);
        chk({tag, "_fr1"}, fr1, 0); chk({tag, "_fz1"}, fz1, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary, expected run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = '0;
        in_exp_result = '0; in_exp_zcv = '0; act_res = 32'hDEADBEEF; act_zcv = 3'b101;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; mon_en = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Test 1: stray issue in IDLE, clean run, start ignored mid-run.
        drive(1, 0, 0, 4'd2, 32'd1, 3'b000, 32'd99, 3'b111);
        pulse_start;
        good(0); good(1);
        start = 1'b1; good(2); start = 1'b0;
        good(3); good(4); good(5);
        wait_done("t1");
        run_end("t1", 6, 0, 2, 0, 1);
`ifdef ALU_CHK_CAPTURE_EN
        chk("t1_fv1", fv1, 0);
        chk("t1_fv2", fv2, 0);
`endif

        // Test 2: ADD overflow flag missing from the ALU.
        pulse_start;
        drive(1, 1, 1, 4'd2, 32'h80000000, 3'b001, 32'h80000000, 3'b000);
        good(1); good(2); good(3); good(4); good(5);
        wait_done("t2");
        run_end("t2", 6, 1, 2, 1, 0);

        // Test 3: SLT ignores cout but not zero; a wrong result always fails.
        pulse_start;
        drive(1, 1, 0, 4'd7, 32'h0, 3'b100, 32'h0, 3'b110);
        drive(1, 1, 1, 4'd7, 32'h0, 3'b100, 32'h0, 3'b010);
        drive(1, 1, 1, 4'd1, 32'hFFFFFFFF, 3'b000, 32'hFFFF0000, 3'b000);
        good(3); good(4); good(5);
        wait_done("t3");
        run_end("t3", 6, 2, 2, 2, 0);

        // Test 4: issue every other cycle, stray issue in DRAIN, exact done timing.
        pulse_start;
        for (int i = 0; i < 6; i++) begin
            good(i);
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1; in_op = 4'd2; in_exp_result = 32'd1; in_exp_zcv = 3'b000;
        act_res = 32'd2; act_zcv = 3'b111;
        @(negedge clk);
        chk("t4_done1_plus1", done1, 0);
        chk("t4_done2_plus1", done2, 0);
        chk("t4_busy2_plus1", busy2, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; act_res = 32'hDEADBEEF; act_zcv = 3'b101;
        @(negedge clk);
        chk("t4_done1_plus2", done1, 1);
        chk("t4_done2_plus2", done2, 0);
        @(negedge clk);
        chk("t4_done2_plus3", done2, 1);
        run_end("t4", 6, 0, 2, 0, 1);

        // Test 5: reset mid-run, then a clean run.
        pulse_start;
        good(0); good(1); good(2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_rst");
        pulse_start;
        for (int i = 0; i < 6; i++) good(i);
        wait_done("t5");
        run_end("t5", 6, 0, 2, 0, 1);

`ifdef ALU_CHK_CAPTURE_EN
        // Test 6: first-failure capture holds against a later failure.
        pulse_start;
        good(0);
        drive(1, 1, 1, 4'd0, 32'h000F000F, 3'b000, 32'h12345678, 3'b100);
        good(2);
        drive(1, 1, 1, 4'd2, 32'h00000008, 3'b000, 32'h00000008, 3'b010);
        good(4); good(5);
        wait_done("t6");
        run_end("t6", 6, 2, 2, 2, 0);
        chk("t6_fv1", fv1, 1); chk("t6_fi1", fi1, 1);
        chk("t6_fr1", fr1, 32'h12345678); chk("t6_fz1", fz1, 3'b100);
        chk("t6_fv2", fv2, 1); chk("t6_fi2", fi2, 1);
        chk("t6_fr2", fr2, 32'h12345678); chk("t6_fz2", fz2, 3'b100);
`endif

        // Test 7: every pattern fails; the 2-bit error counter saturates at 3.
        pulse_start;
`ifdef ALU_CHK_CAPTURE_EN
        chk("t7_fv1_cleared", fv1, 0);
        chk("t7_fi1_cleared", fi1, 0);
`endif
        for (int i = 0; i < 6; i++)
            drive(1, 1, 1, 4'd0, 32'h0, 3'b000, 32'(i + 1), 3'b000);
        wait_done("t7");
        run_end("t7", 6, 6, 2, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
